// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the memory-access pipeline stage.
//
//   Contents:
//     stateT          - memory stage FSM states (IDLE, REQ)
//     MSEL_*          - encodings of the shared bus target select (mem_sel)
//     WB_*            - encodings of the writeback source select (MemToReg)
//     accessNeeded()  - does this instruction touch the shared memory bus
//     accessSelect()  - which target (dmem / pmem / io) the access goes to
//     accessIsWrite() - store (1) or load (0) on the shared bus
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } stateT;

    localparam logic [1:0] MSEL_DMEM = 2'b00;
    localparam logic [1:0] MSEL_PMEM = 2'b01;
    localparam logic [1:0] MSEL_IO   = 2'b10;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_ALU_B  = 2'b01;
    localparam logic [1:0] WB_MEM    = 2'b10;
    localparam logic [1:0] WB_IO     = 2'b11;

    // Any store, any IO reference, or any load (MemToReg selects a memory or
    // IO source) has to go out on the shared bus.
    function automatic logic accessNeeded(
        input logic       memWrite,
        input logic       memPWrite,
        input logic       ioFlag,
        input logic [1:0] memToReg
    );
        logic isLoad;
        isLoad = (memToReg == WB_MEM) || (memToReg == WB_IO);
        return memWrite | memPWrite | ioFlag | isLoad;
    endfunction

    // IO wins over private memory, private memory wins over data memory.
    // An IO load (MemToReg == 11) targets IO even without IOFlag.
    function automatic logic [1:0] accessSelect(
        input logic       memPWrite,
        input logic       ioFlag,
        input logic [1:0] memToReg
    );
        logic [1:0] sel;
        if (ioFlag || (memToReg == WB_IO)) begin
            sel = MSEL_IO;
        end else if (memPWrite) begin
            sel = MSEL_PMEM;
        end else begin
            sel = MSEL_DMEM;
        end
        return sel;
    endfunction

    // An IO reference that does not load into the register file is an IO
    // write; otherwise only explicit stores write.
    function automatic logic accessIsWrite(
        input logic       memWrite,
        input logic       memPWrite,
        input logic       ioFlag,
        input logic [1:0] memToReg
    );
        return memWrite | memPWrite | (ioFlag & ~memToReg[1]);
    endfunction

endpackage

// File: rtl/mem_access_stage_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
//   Counts cycles spent waiting for the shared bus to answer and flags when
//   the last permitted wait cycle has been reached.
//
//   Ports:
//     clk     in   clock, rising edge
//     rst_n   in   asynchronous active-low reset
//     clear   in   restart the count at zero (has priority over enable)
//     enable  in   advance the count by one
//     done    out  count has reached TIMEOUT-1 (combinational from count)
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] waitCount;

    // Wait counter: cleared when a new access is accepted, advanced once per
    // unanswered request cycle. The caller stops enabling it at LAST, so it
    // never wraps while a request is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCount <= '0;
        end else if (clear) begin
            waitCount <= '0;
        end else if (enable) begin
            waitCount <= waitCount + 1'b1;
        end
    end

    assign done = (waitCount == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   Memory stage of the pipeline. Takes the execute-stage results, performs
//   any data-memory, private-memory or IO access over one shared
//   request/ready bus, stalls upstream while that access is outstanding and
//   presents registered results to the writeback mux.
//
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     in_valid            execute-stage outputs valid this cycle
//     RegWrite, MemWrite, MemPWrite, IOFlag, MemToReg, ALUResult, WriteData,
//     Rd                  execute-stage outputs
//     stall               freeze upstream (combinational)
//     mem_req, mem_we, mem_sel, mem_addr, mem_wdata
//                         shared bus request, held stable while mem_req=1
//     mem_rdata, mem_ready
//                         shared bus response
//     wb_valid            one-cycle pulse per retired instruction
//     RegWriteOut, MemToRegOut, ReadDataOut, ALUResultOut, RdOut
//                         registered writeback-stage values
//     timeout_err         sticky flag: some access was abandoned
// ---------------------------------------------------------------------------
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    input  logic             RegWrite,
    input  logic             MemWrite,
    input  logic             MemPWrite,
    input  logic             IOFlag,
    input  logic [1:0]       MemToReg,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [3:0]       Rd,

    output logic             stall,

    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       mem_sel,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,

    output logic             wb_valid,
    output logic             RegWriteOut,
    output logic [1:0]       MemToRegOut,
    output logic [WIDTH-1:0] ReadDataOut,
    output logic [WIDTH-1:0] ALUResultOut,
    output logic [3:0]       RdOut,
    output logic             timeout_err
);

    stateT            state;

    logic             accNeeded;
    logic             accept;
    logic             timerDone;
    logic             timerEnable;

    logic             reqWe;
    logic [1:0]       reqSel;
    logic [WIDTH-1:0] reqAddr;
    logic [WIDTH-1:0] reqWdata;
    logic             pendRegWrite;
    logic [1:0]       pendMemToReg;
    logic [3:0]       pendRd;

    assign accNeeded = accessNeeded(MemWrite, MemPWrite, IOFlag, MemToReg);
    assign accept    = (state == IDLE) && in_valid && accNeeded;

    // Upstream must freeze in the very cycle a bus instruction is presented,
    // not one cycle later, otherwise it would advance past it. Gating with
    // rst_n keeps stall low while the stage is held in reset.
    assign stall = rst_n && ((state == REQ) || accept);

    // The bus side is driven straight from the values latched at acceptance,
    // so it stays stable for the whole request regardless of upstream.
    assign mem_req   = (state == REQ);
    assign mem_we    = reqWe;
    assign mem_sel   = reqSel;
    assign mem_addr  = reqAddr;
    assign mem_wdata = reqWdata;

    // Stop counting at the terminal value: the abort happens on that edge.
    assign timerEnable = (state == REQ) && !mem_ready && !timerDone;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) uWaitTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (timerEnable),
        .done   (timerDone)
    );

    // Stage FSM with registered outputs.
    //   IDLE: a non-bus instruction retires on the next edge; a bus
    //         instruction is latched and the stage moves to REQ.
    //   REQ:  wait for mem_ready. A response retires the instruction
    //         (capturing load data); running out of wait cycles retires it
    //         with RegWriteOut forced low and raises the sticky error.
    // Because retirement returns to IDLE, a new instruction can be accepted
    // in the same cycle its predecessor's wb_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            reqWe        <= 1'b0;
            reqSel       <= MSEL_DMEM;
            reqAddr      <= '0;
            reqWdata     <= '0;
            pendRegWrite <= 1'b0;
            pendMemToReg <= 2'b00;
            pendRd       <= 4'h0;
            wb_valid     <= 1'b0;
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 2'b00;
            ReadDataOut  <= '0;
            ALUResultOut <= '0;
            RdOut        <= 4'h0;
            timeout_err  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (accNeeded) begin
                            reqWe        <= accessIsWrite(MemWrite, MemPWrite, IOFlag, MemToReg);
                            reqSel       <= accessSelect(MemPWrite, IOFlag, MemToReg);
                            reqAddr      <= ALUResult;
                            reqWdata     <= WriteData;
                            pendRegWrite <= RegWrite;
                            pendMemToReg <= MemToReg;
                            pendRd       <= Rd;
                            state        <= REQ;
                        end else begin
                            RegWriteOut  <= RegWrite;
                            MemToRegOut  <= MemToReg;
                            ALUResultOut <= ALUResult;
                            RdOut        <= Rd;
                            wb_valid     <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!reqWe) begin
                            ReadDataOut <= mem_rdata;
                        end
                        RegWriteOut  <= pendRegWrite;
                        MemToRegOut  <= pendMemToReg;
                        ALUResultOut <= reqAddr;
                        RdOut        <= pendRd;
                        wb_valid     <= 1'b1;
                        state        <= IDLE;
                    end else if (timerDone) begin
                        RegWriteOut  <= 1'b0;
                        MemToRegOut  <= pendMemToReg;
                        ALUResultOut <= reqAddr;
                        RdOut        <= pendRd;
                        wb_valid     <= 1'b1;
                        timeout_err  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
